// File: rtl/window_sum_stage.sv
// Sliding-window sum over the last DEPTH accepted samples, with oldest sample, overflow and fill level.
// Define WINDOW_SUM_SATURATE_EN to clamp out_sum at 2^OUT_W-1 instead of wrapping.
module window_sum_stage #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int OUT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [W-1:0]               in_data,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_sum,
    output logic [W-1:0]               out_oldest,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH+1)-1:0] fill_count
);

    localparam int SW = W + $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH+1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_FILLING = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [W-1:0]      r_hist [DEPTH];
    logic [SW-1:0]     r_sum;
    logic [FW-1:0]     r_fill;
    logic [FW-1:0]     w_fill_next;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_sum;
    logic [W-1:0]      r_out_oldest;
    logic              r_out_ovf;

    logic              w_accept;
    logic [W-1:0]      w_evicted;
    logic [SW:0]       w_sum_next;
    logic              w_ovf;
    logic [OUT_W-1:0]  w_out_sum;

    assign w_accept  = in_valid & ~flush;
    assign w_evicted = (r_state == S_FULL) ? r_hist[DEPTH-1] : '0;
    // One spare bit so sum + in_data cannot wrap before the eviction is subtracted.
    assign w_sum_next = {1'b0, r_sum} + (SW+1)'(in_data) - (SW+1)'(w_evicted);
    assign w_ovf      = |(w_sum_next >> OUT_W);

`ifdef WINDOW_SUM_SATURATE_EN
    assign w_out_sum = w_ovf ? '1 : OUT_W'(w_sum_next);
`else
    assign w_out_sum = OUT_W'(w_sum_next);
`endif

    always_comb begin
        w_fill_next = r_fill;
        if (w_accept && (r_fill != FILL_MAX))
            w_fill_next = r_fill + 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else if (w_accept) begin
            case (r_state)
                S_EMPTY:   w_state_next = (w_fill_next == FILL_MAX) ? S_FULL : S_FILLING;
                S_FILLING: w_state_next = (w_fill_next == FILL_MAX) ? S_FULL : S_FILLING;
                S_FULL:    w_state_next = S_FULL;
                default:   w_state_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_EMPTY;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_hist[i] <= '0;
            r_sum        <= '0;
            r_fill       <= '0;
            r_out_valid  <= 1'b0;
            r_out_sum    <= '0;
            r_out_oldest <= '0;
            r_out_ovf    <= 1'b0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_hist[i] <= '0;
            r_sum        <= '0;
            r_fill       <= '0;
            r_out_valid  <= 1'b0;
            r_out_sum    <= '0;
            r_out_oldest <= '0;
            r_out_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_hist[0] <= in_data;
            for (int unsigned i = 1; i < DEPTH; i++)
                r_hist[i] <= r_hist[i-1];
            r_sum       <= w_sum_next[SW-1:0];
            r_fill      <= w_fill_next;
            r_out_valid <= (w_fill_next == FILL_MAX);
            if (w_fill_next == FILL_MAX) begin
                r_out_sum    <= w_out_sum;
                // After the shift, the slot DEPTH-2 moves into the oldest position.
                r_out_oldest <= r_hist[DEPTH-2];
                r_out_ovf    <= w_ovf;
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sum    = r_out_sum;
    assign out_oldest = r_out_oldest;
    assign out_ovf    = r_out_ovf;
    assign fill_count = r_fill;

endmodule

// File: tb/tb_window_sum_stage.sv
// Directed bench for window_sum_stage; expectations follow WINDOW_SUM_SATURATE_EN when defined.
module tb_window_sum_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       flush;
    logic       out_valid;
    logic [3:0] out_sum;
    logic [3:0] out_oldest;
    logic       out_ovf;
    logic [2:0] fill_count;

    int n_total = 0;
    int n_bad   = 0;

    window_sum_stage #(.W(4), .DEPTH(4), .OUT_W(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_sum    (out_sum),
        .out_oldest (out_oldest),
        .out_ovf    (out_ovf),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WINDOW_SUM_SATURATE_EN
    localparam int EXP_SUM_A = 15;
    localparam int EXP_SUM_B = 15;
`else
    localparam int EXP_SUM_A = 3;
    localparam int EXP_SUM_B = 11;
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int ov, input int sum,
                           input int old, input int ovf, input int fill);
        chk({tag, ".valid"},  int'(out_valid),  ov);
        chk({tag, ".sum"},    int'(out_sum),    sum);
        chk({tag, ".oldest"}, int'(out_oldest), old);
        chk({tag, ".ovf"},    int'(out_ovf),    ovf);
        chk({tag, ".fill"},   int'(fill_count), fill);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 1'b0);
            chk_out("idle", 0, 0, 0, 0, 0);
        end

        // Fill and steady state: 1,2,15,1,9
        drive(1'b1, 4'd1, 1'b0);  chk_out("fill1", 0, 0, 0, 0, 1);
        drive(1'b1, 4'd2, 1'b0);  chk_out("fill2", 0, 0, 0, 0, 2);
        drive(1'b1, 4'd15, 1'b0); chk_out("fill3", 0, 0, 0, 0, 3);
        drive(1'b1, 4'd1, 1'b0);  chk_out("full4", 1, EXP_SUM_A, 1, 1, 4);
        drive(1'b1, 4'd9, 1'b0);  chk_out("full5", 1, EXP_SUM_B, 2, 1, 4);
        drive(1'b0, 4'd0, 1'b0);  chk_out("hold",  0, EXP_SUM_B, 2, 1, 4);

        drive(1'b0, 4'd0, 1'b1);  chk_out("flush", 0, 0, 0, 0, 0);

        // Gaps in input
        drive(1'b1, 4'd1, 1'b0);  chk_out("gap1", 0, 0, 0, 0, 1);
        drive(1'b1, 4'd1, 1'b0);  chk_out("gap2", 0, 0, 0, 0, 2);
        drive(1'b0, 4'd0, 1'b0);  chk_out("gapidle1", 0, 0, 0, 0, 2);
        drive(1'b0, 4'd0, 1'b0);  chk_out("gapidle2", 0, 0, 0, 0, 2);
        drive(1'b1, 4'd1, 1'b0);  chk_out("gap3", 0, 0, 0, 0, 3);
        drive(1'b1, 4'd1, 1'b0);  chk_out("gap4", 1, 4, 1, 0, 4);
        drive(1'b0, 4'd0, 1'b0);  chk_out("gapend", 0, 4, 1, 0, 4);

        // Flush with simultaneous sample
        drive(1'b0, 4'd0, 1'b1);
        drive(1'b1, 4'd5, 1'b0);
        drive(1'b1, 4'd5, 1'b0);
        drive(1'b1, 4'd5, 1'b0);  chk("pre_flush.fill", int'(fill_count), 3);
        drive(1'b1, 4'd7, 1'b1);  chk_out("flush_win", 0, 0, 0, 0, 0);
        drive(1'b1, 4'd2, 1'b0);  chk_out("twos1", 0, 0, 0, 0, 1);
        drive(1'b1, 4'd2, 1'b0);  chk_out("twos2", 0, 0, 0, 0, 2);
        drive(1'b1, 4'd2, 1'b0);  chk_out("twos3", 0, 0, 0, 0, 3);
        drive(1'b1, 4'd2, 1'b0);  chk_out("twos4", 1, 8, 2, 0, 4);
        drive(1'b1, 4'd3, 1'b0);  chk_out("twos5", 1, 9, 2, 0, 4);

        // Async reset mid-cycle while FULL
        in_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 4'd6, 1'b0);  chk_out("post_rst", 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/window_sum_stage.md
Name: window_sum_stage

Overview:
- Downstream consumer of the mixed-op delay stage's 4-bit result stream. That stage's `c` output feeds this block's `in_data`.
- Keeps the last DEPTH accepted samples in a history buffer and produces a registered sliding-window sum of those samples.
- Also produces the oldest sample in the window, an overflow flag and the fill level.
- Used to check that the delay/arithmetic pipeline keeps producing data in steady state.

Parameters:
- W, 4, width of each input sample.
- DEPTH, 4, number of samples in the window; must be at least 2.
- OUT_W, 4, width of out_sum. Internal sum width is SW = W + $clog2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-low (rst=0 resets).
- in_valid  input  1  in_data is a sample to accept this cycle.
- in_data  input  W  sample value, unsigned.
- flush  input  1  synchronous clear of the window.
- out_valid  output  1  out_sum/out_oldest are valid for the sample accepted last cycle.
- out_sum  output  OUT_W  sliding sum of the last DEPTH samples, reduced to OUT_W bits.
- out_oldest  output  W  oldest sample currently in the window.
- out_ovf  output  1  full internal sum exceeded 2^OUT_W-1.
- fill_count  output  $clog2(DEPTH+1)  number of valid samples in the window.

Behaviour:
- Reset (rst=0, asynchronous):
  - History buffer, internal sum and fill_count go to 0.
  - out_valid, out_sum, out_oldest and out_ovf go to 0.
  - State goes to EMPTY.
  - Reset asserted mid-stream discards all history immediately, with no waiting for a clock edge.
- States:
  - EMPTY: fill_count = 0.
  - FILLING: 1 <= fill_count < DEPTH.
  - FULL: fill_count = DEPTH.
- Accept rule: a sample is accepted on a clock edge where in_valid=1 and flush=0. There is no backpressure; every valid sample is taken.
- On accept:
  - The sample is shifted into the history buffer.
  - Internal sum (SW bits, exact) becomes sum + in_data - evicted.
  - evicted is the sample leaving the window in FULL; it is 0 in EMPTY and FILLING.
  - fill_count increments, saturating at DEPTH.
- State transitions:
  - EMPTY to FILLING on the first accept.
  - FILLING to FULL on the accept that makes fill_count = DEPTH.
  - FULL stays FULL on further accepts.
- Output latency: 1 cycle.
  - out_valid=1 on the cycle after an accept for which the post-accept fill_count = DEPTH, i.e. from the DEPTH-th sample onward.
  - out_valid=0 otherwise, including cycles with in_valid=0.
  - out_sum, out_oldest and out_ovf update together with out_valid.
  - Between valid outputs they hold their last value.
- Arithmetic:
  - Internal sum never wraps (SW bits are always sufficient).
  - out_ovf = (internal sum > 2^OUT_W - 1) for the same update.
  - Reduction of the internal sum to OUT_W bits is set by the optional feature below.
- flush=1 at a clock edge:
  - History, internal sum and fill_count go to 0; state goes to EMPTY.
  - out_valid=0 on the next cycle.
  - out_sum, out_oldest and out_ovf go to 0.
  - If in_valid=1 in the same cycle, flush wins and the sample is dropped.
- Idle: in_valid=0 with flush=0 changes nothing except that out_valid drops to 0.

Optional Feature:
- Macro: WINDOW_SUM_SATURATE_EN.
- Defined: out_sum = min(internal sum, 2^OUT_W - 1).
- Undefined: out_sum = internal sum mod 2^OUT_W (wrap).
- out_ovf behaves identically in both builds.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 with in_valid=0 for 3 cycles -> all outputs 0, fill_count=0 throughout.
- Fill and steady state, default params, wrap build: accept 1,2,15,1,9 on consecutive cycles.
  - out_valid first rises the cycle after sample 4 with out_sum=3 (19 mod 16), out_ovf=1, out_oldest=1.
  - Next cycle: out_sum=11 (27 mod 16), out_ovf=1, out_oldest=2.
  - fill_count reads 1,2,3,4,4.
- Saturate build, same stimulus as above -> out_sum=15 and 15, out_ovf=1 on both.
- Gaps in input: accept 1,1, then in_valid=0 for 2 cycles, then accept 1,1.
  - out_valid pulses exactly once, after the 4th sample, with out_sum=4 and out_ovf=0.
  - fill_count holds at 2 during the gap.
- Flush with simultaneous sample: after 3 accepts, assert flush=1 together with in_valid=1, in_data=7 -> fill_count=0 next cycle, 7 not stored; the next 4 accepts of 2 give out_sum=8.
- Async reset mid-stream: with window FULL, drop rst low mid-cycle -> outputs and fill_count read 0 before the next clk edge.
